// File: rtl/mem_pkg.sv
// Data-memory types shared by the load/store unit and the memory side.
package mem_pkg;

    typedef enum logic [1:0] {
        WRITE_DISABLED  = 2'd0,
        WRITE_BYTE      = 2'd1,
        WRITE_HALF_WORD = 2'd2,
        WRITE_WORD      = 2'd3
    } dm_write_type_t;

    typedef enum logic [2:0] {
        ORIGINAL           = 3'd0,
        BYTE_SIGNED        = 3'd1,
        BYTE_UNSIGNED      = 3'd2,
        HALF_WORD_SIGNED   = 3'd3,
        HALF_WORD_UNSIGNED = 3'd4
    } dm_read_extract_extend_type_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } lsu_state_t;

    localparam logic [3:0] BYTE_LANE_ENABLE = 4'b0001;
    localparam logic [3:0] HALF_LOW_ENABLE  = 4'b0011;
    localparam logic [3:0] HALF_HIGH_ENABLE = 4'b1100;
    localparam logic [3:0] WORD_ENABLE      = 4'b1111;

    typedef struct packed {
        logic [1:0]                   byteOffset;
        dm_write_type_t               writeType;
        dm_read_extract_extend_type_t extendType;
    } lsu_request_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane placement for stores, lane extract/extend for loads,
// and the alignment check for both.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]                   byteOffset,
    input  dm_write_type_t               writeType,
    input  dm_read_extract_extend_type_t extendType,
    input  logic [31:0]                  storeData,
    input  logic [31:0]                  loadWord,
    output logic [3:0]                   byteEnable,
    output logic [31:0]                  laneData,
    output logic [31:0]                  loadData,
    output logic                         misaligned
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    assign loadByte = loadWord[{byteOffset, 3'b000} +: 8];
    assign loadHalf = byteOffset[1] ? loadWord[31:16] : loadWord[15:0];

    always_comb begin
        byteEnable = WORD_ENABLE;
        laneData   = '0;
        misaligned = 1'b0;
        unique case (writeType)
            WRITE_BYTE: begin
                byteEnable = BYTE_LANE_ENABLE << byteOffset;
                laneData   = {4{storeData[7:0]}};
            end
            WRITE_HALF_WORD: begin
                byteEnable = byteOffset[1] ? HALF_HIGH_ENABLE
                                           : HALF_LOW_ENABLE;
                laneData   = {2{storeData[15:0]}};
                misaligned = byteOffset[0];
            end
            WRITE_WORD: begin
                laneData   = storeData;
                misaligned = |byteOffset;
            end
            default: begin
                // Loads: width comes from the extend type.
                case (extendType)
                    BYTE_SIGNED,
                    BYTE_UNSIGNED:      misaligned = 1'b0;
                    HALF_WORD_SIGNED,
                    HALF_WORD_UNSIGNED: misaligned = byteOffset[0];
                    default:            misaligned = |byteOffset;
                endcase
            end
        endcase
    end

    always_comb begin
        loadData = loadWord;
        case (extendType)
            BYTE_SIGNED:
                loadData = {{24{loadByte[7]}}, loadByte};
            BYTE_UNSIGNED:
                loadData = {24'h0, loadByte};
            HALF_WORD_SIGNED:
                loadData = {{16{loadHalf[15]}}, loadHalf};
            HALF_WORD_UNSIGNED:
                loadData = {16'h0, loadHalf};
            default:
                loadData = loadWord;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Pipeline-side data-memory initiator: one access in flight,
// req/ack bus with byte enables and an acknowledge timeout.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddress,
    input  logic [1:0]  reqWriteType,
    input  logic [2:0]  reqExtendType,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respMisaligned,
    output logic        respTimeout,
    output logic        memRequest,
    output logic        memWrite,
    output logic [29:0] memAddress,
    output logic [3:0]  memByteEnable,
    output logic [31:0] memWriteData,
    input  logic        memAck,
    input  logic [31:0] memReadData
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t   state;
    lsu_request_t held;
    lsu_request_t incoming;
    lsu_request_t active;
    logic [15:0]  timeoutCount;

    logic [3:0]   alignByteEnable;
    logic [31:0]  alignLaneData;
    logic [31:0]  alignLoadData;
    logic         alignMisaligned;

    assign reqReady = resetN && (state == IDLE);

    assign incoming.byteOffset = reqAddress[1:0];
    assign incoming.writeType  = dm_write_type_t'(reqWriteType);
    assign incoming.extendType =
        dm_read_extract_extend_type_t'(reqExtendType);

    // In IDLE the aligner sees the new request, otherwise the held one.
    assign active = (state == IDLE) ? incoming : held;

    lsu_lane_align alignUnit (
        .byteOffset (active.byteOffset),
        .writeType  (active.writeType),
        .extendType (active.extendType),
        .storeData  (reqWriteData),
        .loadWord   (memReadData),
        .byteEnable (alignByteEnable),
        .laneData   (alignLaneData),
        .loadData   (alignLoadData),
        .misaligned (alignMisaligned)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state          <= IDLE;
            held           <= '0;
            timeoutCount   <= '0;
            respValid      <= 1'b0;
            respData       <= '0;
            respMisaligned <= 1'b0;
            respTimeout    <= 1'b0;
            memRequest     <= 1'b0;
            memWrite       <= 1'b0;
            memAddress     <= '0;
            memByteEnable  <= '0;
            memWriteData   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqValid) begin
                        held         <= incoming;
                        timeoutCount <= '0;
                        if (alignMisaligned) begin
                            respValid      <= 1'b1;
                            respMisaligned <= 1'b1;
                            respTimeout    <= 1'b0;
                            respData       <= '0;
                            state          <= RESPOND;
                        end else begin
                            memRequest    <= 1'b1;
                            memWrite      <=
                                incoming.writeType != WRITE_DISABLED;
                            memAddress    <= reqAddress[31:2];
                            memByteEnable <= alignByteEnable;
                            memWriteData  <= alignLaneData;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (memAck) begin
                        memRequest  <= 1'b0;
                        respValid   <= 1'b1;
                        respTimeout <= 1'b0;
                        respData    <=
                            (held.writeType == WRITE_DISABLED)
                            ? alignLoadData : 32'h0;
                        state       <= RESPOND;
                    end else if (timeoutCount == TIMEOUT_LAST) begin
                        memRequest  <= 1'b0;
                        respValid   <= 1'b1;
                        respTimeout <= 1'b1;
                        respData    <= '0;
                        state       <= RESPOND;
                    end else begin
                        timeoutCount <= timeoutCount + 16'd1;
                    end
                end
                RESPOND: begin
                    respValid      <= 1'b0;
                    respMisaligned <= 1'b0;
                    respTimeout    <= 1'b0;
                    respData       <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
